// File: rtl/ita_stream_sequencer_pkg.sv
// Shared types for the ITA stream sequencer: FSM states, the queued job record and tile-length helper.
package ita_hwpe_package;

    localparam int unsigned JOB_ADDR_W = 32;
    localparam int unsigned JOB_N_WPTR = 4;
    localparam int unsigned JOB_NW_W   = $clog2(JOB_N_WPTR) + 1;

    typedef enum logic [1:0] {
        SeqIdle,
        SeqLaunch,
        SeqWeight,
        SeqDrain
    } seq_state_e;

    typedef struct packed {
        logic [JOB_ADDR_W-1:0]                 input_addr;
        logic [JOB_ADDR_W-1:0]                 bias_addr;
        logic [JOB_ADDR_W-1:0]                 output_addr;
        logic [JOB_N_WPTR-1:0][JOB_ADDR_W-1:0] weight_addr;
        logic [JOB_NW_W-1:0]                   n_weight;
        logic                                  weight_preload;
        logic                                  bias_disable;
        logic                                  output_disable;
    } job_t;

    function automatic int unsigned tot_len(input int unsigned m, input int unsigned n);
        return (m * m) / n;
    endfunction

endpackage

// File: rtl/ita_job_fifo.sv
// Synchronous job queue, head visible combinationally; push/pop same cycle keeps count.
// Caller guarantees no push when full and no pop when empty; flush empties in one cycle.
module ita_job_fifo
    import ita_hwpe_package::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  job_t                   dat_i,
    input  logic                   pop_i,
    output job_t                   dat_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    job_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= dat_i;
    end

    assign dat_o   = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/ita_stream_sequencer.sv
// Queued job launcher for the ITA streams: pop -> LAUNCH next cycle, first weight_start 2 cycles after pop.
// job_ready_o drops only when the queue is full; a job retires when engine and streams report drained.
module ita_stream_sequencer
    import ita_hwpe_package::*;
#(
    parameter int unsigned M            = 64,
    parameter int unsigned N            = 16,
    parameter int unsigned N_WEIGHT_PTR = JOB_N_WPTR,
    parameter int unsigned QUEUE_DEPTH  = 2,
    parameter int unsigned ADDR_W       = JOB_ADDR_W,
    parameter int unsigned LEN_W        = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             job_valid_i,
    output logic                             job_ready_o,
    input  logic [ADDR_W-1:0]                job_input_addr_i,
    input  logic [ADDR_W-1:0]                job_bias_addr_i,
    input  logic [ADDR_W-1:0]                job_output_addr_i,
    input  logic [N_WEIGHT_PTR*ADDR_W-1:0]   job_weight_addr_i,
    input  logic [$clog2(N_WEIGHT_PTR):0]    job_n_weight_i,
    input  logic                             job_weight_preload_i,
    input  logic                             job_bias_disable_i,
    input  logic                             job_output_disable_i,
    output logic [ADDR_W-1:0]                input_addr_o,
    output logic [ADDR_W-1:0]                bias_addr_o,
    output logic [ADDR_W-1:0]                output_addr_o,
    output logic [ADDR_W-1:0]                weight_base_addr_o,
    output logic [LEN_W-1:0]                 weight_len_o,
    output logic                             input_start_o,
    output logic                             bias_start_o,
    output logic                             output_start_o,
    output logic                             weight_start_o,
    output logic                             engine_start_o,
    input  logic                             weight_done_i,
    input  logic                             input_ready_i,
    input  logic                             bias_ready_i,
    input  logic                             weight_ready_i,
    input  logic                             output_ready_i,
    input  logic [1:0]                       fifo_empty_i,
    input  logic                             engine_busy_i,
    output logic [$clog2(N_WEIGHT_PTR)-1:0]  seg_idx_o,
    output logic [$clog2(QUEUE_DEPTH):0]     queue_count_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             clear_o
);
    localparam int unsigned SEG_W = $clog2(N_WEIGHT_PTR);
    localparam int unsigned NW_W  = $clog2(N_WEIGHT_PTR) + 1;
    localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(tot_len(M, N) / 8);
    localparam logic [LEN_W-1:0]  LEN_SEG  = LEN_W'(M / 8);
    localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(N * M);

    seq_state_e        state_q;
    job_t              job_q, push_dat, head_dat;
    logic              push, pop, fifo_empty, fifo_full, more_seg, retire_ok;
    logic [SEG_W-1:0]  seg_idx_q, seg_nxt;
    logic [ADDR_W-1:0] weight_base_q;
    logic [LEN_W-1:0]  weight_len_q;
    logic              input_start_q, bias_start_q, output_start_q, weight_start_q, engine_start_q;
    logic              done_q, clear_q;

    always_comb begin
        push_dat                = '0;
        push_dat.input_addr     = job_input_addr_i;
        push_dat.bias_addr      = job_bias_addr_i;
        push_dat.output_addr    = job_output_addr_i;
        push_dat.weight_addr    = job_weight_addr_i;
        push_dat.weight_preload = job_weight_preload_i;
        push_dat.bias_disable   = job_bias_disable_i;
        push_dat.output_disable = job_output_disable_i;
        push_dat.n_weight       = job_n_weight_i;
        if (job_n_weight_i == '0)
            push_dat.n_weight = NW_W'(1);
        else if (job_n_weight_i > NW_W'(N_WEIGHT_PTR))
            push_dat.n_weight = NW_W'(N_WEIGHT_PTR);
    end

    assign push = job_valid_i & ~fifo_full & ~clear_i;
    assign pop  = (state_q == SeqIdle) & ~fifo_empty & ~clear_i;

    ita_job_fifo #(.DEPTH(QUEUE_DEPTH)) u_job_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (clear_i),
        .push_i  (push),
        .dat_i   (push_dat),
        .pop_i   (pop),
        .dat_o   (head_dat),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (queue_count_o)
    );

    assign seg_nxt  = seg_idx_q + 1'b1;
    assign more_seg = ({1'b0, seg_idx_q} + NW_W'(1)) < job_q.n_weight;
    // Without an output stream the engine itself must go idle before the job can retire.
    assign retire_ok = job_q.output_disable
                     ? (~engine_busy_i & input_ready_i & weight_ready_i & bias_ready_i)
                     : (output_ready_i & weight_ready_i & (fifo_empty_i == 2'b11));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q        <= SeqIdle;
            job_q          <= '0;
            seg_idx_q      <= '0;
            weight_base_q  <= '0;
            weight_len_q   <= '0;
            input_start_q  <= 1'b0;
            bias_start_q   <= 1'b0;
            output_start_q <= 1'b0;
            weight_start_q <= 1'b0;
            engine_start_q <= 1'b0;
            done_q         <= 1'b0;
            clear_q        <= clear_i & ~rst_i;
        end else begin
            input_start_q  <= 1'b0;
            bias_start_q   <= 1'b0;
            output_start_q <= 1'b0;
            weight_start_q <= 1'b0;
            engine_start_q <= 1'b0;
            done_q         <= 1'b0;
            clear_q        <= 1'b0;
            case (state_q)
                SeqIdle: begin
                    if (!fifo_empty) begin
                        job_q          <= head_dat;
                        seg_idx_q      <= '0;
                        input_start_q  <= 1'b1;
                        engine_start_q <= 1'b1;
                        bias_start_q   <= ~head_dat.bias_disable;
                        output_start_q <= ~head_dat.output_disable;
                        state_q        <= SeqLaunch;
                    end
                end
                SeqLaunch: begin
                    weight_len_q   <= job_q.weight_preload ? LEN_FULL : LEN_FULL - LEN_SEG;
                    weight_base_q  <= job_q.weight_preload ? job_q.weight_addr[0]
                                                           : job_q.weight_addr[0] + PRE_OFS;
                    weight_start_q <= 1'b1;
                    state_q        <= SeqWeight;
                end
                SeqWeight: begin
                    if (weight_done_i) begin
                        if (more_seg) begin
                            seg_idx_q      <= seg_nxt;
                            weight_base_q  <= job_q.weight_addr[seg_nxt];
                            weight_len_q   <= LEN_SEG;
                            weight_start_q <= 1'b1;
                        end else begin
                            state_q <= SeqDrain;
                        end
                    end
                end
                SeqDrain: begin
                    if (retire_ok) begin
                        done_q  <= 1'b1;
                        clear_q <= 1'b1;
                        state_q <= SeqIdle;
                    end
                end
                default: state_q <= SeqIdle;
            endcase
        end
    end

    assign job_ready_o        = ~fifo_full;
    assign input_addr_o       = job_q.input_addr;
    assign bias_addr_o        = job_q.bias_addr;
    assign output_addr_o      = job_q.output_addr;
    assign weight_base_addr_o = weight_base_q;
    assign weight_len_o       = weight_len_q;
    assign input_start_o      = input_start_q;
    assign bias_start_o       = bias_start_q;
    assign output_start_o     = output_start_q;
    assign weight_start_o     = weight_start_q;
    assign engine_start_o     = engine_start_q;
    assign seg_idx_o          = seg_idx_q;
    assign busy_o             = (state_q != SeqIdle);
    assign done_o             = done_q;
    assign clear_o            = clear_q;

endmodule
